mips_dmem_responder: RTL and testbench

//   Data-memory responder for the processor's load/store port. Accepts one

---
 rtl/mips_dmem_responder.sv | 137 +++++++++++++
 tb/tb_mips_dmem_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mips_dmem_responder.sv
// Data-memory responder for the core load/store port: valid/ready request,
// fixed access latency, commit on entry to RESP, response held until accepted.
module mips_dmem_responder #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      CNT_INIT = 4'(LATENCY - 2);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                req_ready_q;
    logic                rsp_valid_q;
    logic                rsp_err_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                accept;
    logic                go_resp;
    logic                acc_we;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_wdata;
    logic                acc_oob;
    logic [IDX_W-1:0]    acc_idx;

    // With LATENCY==1 the access commits on the accept edge, so the live
    // request fields are used instead of the not-yet-latched copies.
    always_comb begin
        accept = (state_q == IDLE) && req_valid && req_ready_q;
        if (state_q == IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
        go_resp = (accept && (LATENCY == 1)) || ((state_q == WAIT) && (cnt_q == 4'd0));
        acc_oob = ({1'b0, acc_addr} >= DEPTH_L);
        acc_idx = acc_addr[IDX_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            mem_q       <= '{default: '0};
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q        <= req_we;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        req_ready_q <= 1'b0;
                        if (LATENCY == 1) begin
                            state_q <= RESP;
                        end else begin
                            cnt_q   <= CNT_INIT;
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase

            if (go_resp) begin
                rsp_valid_q <= 1'b1;
                if (acc_oob) begin
                    rsp_err_q   <= 1'b1;
                    rsp_rdata_q <= '0;
                end else if (acc_we) begin
                    mem_q[acc_idx] <= acc_wdata;
                    rsp_err_q      <= 1'b0;
                    rsp_rdata_q    <= '0;
                end else begin
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= mem_q[acc_idx];
                end
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Directed bench for mips_dmem_responder: vector table of single transactions
// on the default build, hand sequences for stall, reset-in-WAIT and LATENCY=1.
module tb_mips_dmem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
    logic [5:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        req_valid1 = 1'b0, req_we1 = 1'b0, rsp_ready1 = 1'b0;
    logic [5:0]  req_addr1 = '0;
    logic [31:0] req_wdata1 = '0;
    logic        req_ready1, rsp_valid1, rsp_err1;
    logic [31:0] rsp_rdata1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mips_dmem_responder #(.ADDR_W(6), .DATA_W(32), .DEPTH(32), .LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    mips_dmem_responder #(.ADDR_W(6), .DATA_W(32), .DEPTH(32), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
        .req_addr(req_addr1), .req_wdata(req_wdata1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
        .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
    );

    typedef struct {
        logic        we;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction on the LATENCY=2 build; scrambles req_* after accept.
    task automatic txn(input logic we, input logic [5:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output logic er, output int lat);
        int n;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        n = 0;
        while (!req_ready && n < 20) begin tick(); n++; end
        if (n >= 20) check("ready_timeout", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0; req_we = ~we; req_addr = ~addr; req_wdata = ~wdata;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            check("ready_low_wait", 32'(req_ready), 32'd0);
            tick();
            lat++;
        end
        rd = rsp_rdata; er = rsp_err;
        check("ready_low_resp", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("valid_drop", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          accepts;
        int          k_acc;
        logic        was_ready;

        vecs[0]  = '{1'b0, 6'd5,  32'h0,        32'h0,        1'b0};
        vecs[1]  = '{1'b1, 6'd3,  32'hDEADBEEF, 32'h0,        1'b0};
        vecs[2]  = '{1'b0, 6'd3,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b0, 6'd40, 32'h0,        32'h0,        1'b1};
        vecs[4]  = '{1'b1, 6'd40, 32'hFFFFFFFF, 32'h0,        1'b1};
        vecs[5]  = '{1'b0, 6'd8,  32'h0,        32'h0,        1'b0};
        vecs[6]  = '{1'b0, 6'd31, 32'h0,        32'h0,        1'b0};
        vecs[7]  = '{1'b1, 6'd31, 32'hA5A5A5A5, 32'h0,        1'b0};
        vecs[8]  = '{1'b0, 6'd31, 32'h0,        32'hA5A5A5A5, 1'b0};
        vecs[9]  = '{1'b0, 6'd32, 32'h0,        32'h0,        1'b1};
        vecs[10] = '{1'b0, 6'd63, 32'h0,        32'h0,        1'b1};
        vecs[11] = '{1'b1, 6'd0,  32'h11111111, 32'h0,        1'b0};
        vecs[12] = '{1'b0, 6'd0,  32'h0,        32'h11111111, 1'b0};
        vecs[13] = '{1'b0, 6'd3,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[14] = '{1'b0, 6'd30, 32'h0,        32'h0,        1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b0;
        tick();

        foreach (vecs[i]) begin
            txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'd2);
        end

        // Response stall: held outputs, competing request must wait.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd3; req_wdata = '0;
        tick();
        req_we = 1'b1; req_addr = 6'd7; req_wdata = 32'h55;
        tick();
        for (int c = 0; c < 5; c++) begin
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_rdata", rsp_rdata, 32'hDEADBEEF);
            check("stall_ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("stall_release_valid", 32'(rsp_valid), 32'd0);
        check("stall_release_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b0;
        txn(1'b0, 6'd7, 32'h0, rd, er, lat);
        check("stall_no_store", rd, 32'h0);

        // Reset while a store is waiting: store dropped, memory cleared.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd7; req_wdata = 32'h1234;
        tick();
        req_valid = 1'b0;
        check("wait_ready_low", 32'(req_ready), 32'd0);
        check("wait_valid_low", 32'(rsp_valid), 32'd0);
        reset = 1'b1;
        #1;
        check("async_rst_ready", 32'(req_ready), 32'd1);
        check("async_rst_valid", 32'(rsp_valid), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        txn(1'b0, 6'd7, 32'h0, rd, er, lat);
        check("rst_wait_addr7", rd, 32'h0);
        txn(1'b0, 6'd3, 32'h0, rd, er, lat);
        check("rst_cleared_addr3", rd, 32'h0);

        // LATENCY=1 build: store then stream loads, rsp_ready held high.
        rsp_ready1 = 1'b1;
        req_valid1 = 1'b1; req_we1 = 1'b1; req_addr1 = 6'd2; req_wdata1 = 32'hCAFE0001;
        accepts = 0;
        k_acc = 0;
        for (int k = 0; k < 8; k++) begin
            was_ready = req_ready1;
            check($sformatf("l1_ready_%0d", k), 32'(was_ready), 32'((k % 2) == 0));
            tick();
            if (was_ready) begin
                accepts++;
                check($sformatf("l1_valid_%0d", k), 32'(rsp_valid1), 32'd1);
                check($sformatf("l1_rdata_%0d", k), rsp_rdata1,
                      (k_acc == 0) ? 32'h0 : 32'hCAFE0001);
                k_acc++;
                req_we1 = 1'b0;
            end else begin
                check($sformatf("l1_idle_valid_%0d", k), 32'(rsp_valid1), 32'd0);
            end
        end
        check("l1_accepts", 32'(accepts), 32'd4);
        req_valid1 = 1'b0;
        rsp_ready1 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
